// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD requester.
// Imported by the interface, the top and the timer.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;
  localparam int GCD_TIMEOUT_DEFAULT = 512;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } gcd_req_state_t;

endpackage

// File: rtl/gcd_requester_if.sv
// Request, core and response signals of one requester.
// master = requester side, slave = environment side.
interface gcd_requester_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
);

  logic             REQ_VALID;
  logic             REQ_READY;
  logic [WIDTH-1:0] REQ_A;
  logic [WIDTH-1:0] REQ_B;
  logic [WIDTH-1:0] GCD_A;
  logic [WIDTH-1:0] GCD_B;
  logic             GCD_START;
  logic [WIDTH-1:0] GCD_Y;
  logic             GCD_DONE;
  logic             GCD_ERROR;
  logic             RSP_VALID;
  logic             RSP_READY;
  logic [WIDTH-1:0] RSP_Y;
  logic             RSP_ERR;
  logic             RSP_TIMEOUT;

  modport master (
    input  REQ_VALID,
    input  REQ_A,
    input  REQ_B,
    input  GCD_Y,
    input  GCD_DONE,
    input  GCD_ERROR,
    input  RSP_READY,
    output REQ_READY,
    output GCD_A,
    output GCD_B,
    output GCD_START,
    output RSP_VALID,
    output RSP_Y,
    output RSP_ERR,
    output RSP_TIMEOUT
  );

  modport slave (
    output REQ_VALID,
    output REQ_A,
    output REQ_B,
    output GCD_Y,
    output GCD_DONE,
    output GCD_ERROR,
    output RSP_READY,
    input  REQ_READY,
    input  GCD_A,
    input  GCD_B,
    input  GCD_START,
    input  RSP_VALID,
    input  RSP_Y,
    input  RSP_ERR,
    input  RSP_TIMEOUT
  );

endinterface

// File: rtl/gcd_timeout_cnt.sv
// Saturating WAIT-cycle timer for the GCD requester.
// expired flags the last allowed WAIT cycle.
module gcd_timeout_cnt
  import gcd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = (cnt_q == LAST);

  // Holds at LAST so a stalled enable can never wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_requester.sv
// Initiator-side sequencer for one GCD core.
// Issues operand pairs, waits for the result pulse or a timeout.
module gcd_requester
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int TIMEOUT_CYCLES = GCD_TIMEOUT_DEFAULT
) (
  input logic              CLK,
  input logic              RST_N,
  gcd_requester_if.master  bus
);

  gcd_req_state_t state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             err_q, err_d;
  logic             to_q, to_d;
  logic             rdy_q, rdy_d;
  logic             start_q, start_d;
  logic             vld_q, vld_d;

  logic tmr_clr;
  logic tmr_en;
  logic expired;

  assign tmr_clr = (state_q == ISSUE);
  assign tmr_en  = (state_q == WAIT);

  gcd_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    y_d     = y_q;
    err_d   = err_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (bus.REQ_VALID) begin
          opa_d   = bus.REQ_A;
          opb_d   = bus.REQ_B;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        // ERROR beats DONE; any pulse beats the timeout
        if (bus.GCD_ERROR) begin
          y_d     = '0;
          err_d   = 1'b1;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (bus.GCD_DONE) begin
          y_d     = bus.GCD_Y;
          err_d   = 1'b0;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (expired) begin
          y_d     = '0;
          err_d   = 1'b0;
          to_d    = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d   = (state_d == IDLE);
    start_d = (state_d == ISSUE);
    vld_d   = (state_d == RESP);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      rdy_q   <= 1'b1;
      start_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      y_q     <= y_d;
      err_q   <= err_d;
      to_q    <= to_d;
      rdy_q   <= rdy_d;
      start_q <= start_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.REQ_READY   = rdy_q;
  assign bus.GCD_A       = opa_q;
  assign bus.GCD_B       = opb_q;
  assign bus.GCD_START   = start_q;
  assign bus.RSP_VALID   = vld_q;
  assign bus.RSP_Y       = y_q;
  assign bus.RSP_ERR     = err_q;
  assign bus.RSP_TIMEOUT = to_q;

endmodule

// File: doc/gcd_requester.md
# gcd_requester

Initiator-side sequencer for the `GCD` core. It accepts operand pairs from an upstream valid/ready channel and drives the core's `A`/`B`/`START` pins. It captures the single-cycle `DONE`/`ERROR` result pulse, guards against a hung core with a timeout, and holds the result on a downstream valid/ready channel until it is consumed. It sits between the system bus adapter and the `GCD` instance, one requester per core.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width; must match the core.
- `TIMEOUT_CYCLES`, 512, maximum number of WAIT cycles before a timeout is reported; legal range 2..65535.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `REQ_VALID` in 1: upstream operand pair valid.
- `REQ_READY` out 1: requester can accept a pair.
- `REQ_A` in WIDTH: operand A.
- `REQ_B` in WIDTH: operand B.
- `GCD_A` out WIDTH: to core `A`.
- `GCD_B` out WIDTH: to core `B`.
- `GCD_START` out 1: to core `START`.
- `GCD_Y` in WIDTH: from core `Y`.
- `GCD_DONE` in 1: from core `DONE`.
- `GCD_ERROR` in 1: from core `ERROR`.
- `RSP_VALID` out 1: result valid.
- `RSP_READY` in 1: downstream accepts result.
- `RSP_Y` out WIDTH: GCD result.
- `RSP_ERR` out 1: core reported a zero operand.
- `RSP_TIMEOUT` out 1: no core response within `TIMEOUT_CYCLES`.

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - `REQ_READY`=1.
  - On `REQ_VALID`&`REQ_READY`: latch `REQ_A`/`REQ_B` into operand registers, go to ISSUE.
- **ISSUE**
  - `GCD_START`=1 for exactly this one cycle; `GCD_A`/`GCD_B` = latched operands.
  - Clear the timer, go to WAIT.
- **WAIT**
  - The timer increments each cycle.
  - `GCD_DONE`=1: capture `GCD_Y` into `RSP_Y`; `RSP_ERR`=0, `RSP_TIMEOUT`=0; go to RESP.
  - `GCD_ERROR`=1: `RSP_Y`=0, `RSP_ERR`=1; go to RESP. If `GCD_ERROR` and `GCD_DONE` are both high, ERROR wins.
  - Timer reaches `TIMEOUT_CYCLES`-1 with neither input high: `RSP_Y`=0, `RSP_TIMEOUT`=1; go to RESP. If a core pulse arrives in the same cycle, the pulse wins.
- **RESP**
  - `RSP_VALID`=1; `RSP_Y`/`RSP_ERR`/`RSP_TIMEOUT` are held stable.
  - On `RSP_READY`: go to IDLE.

General rules:
- `GCD_A`/`GCD_B` always show the latched operands; they change only on acceptance.
- `GCD_DONE`/`GCD_ERROR` are ignored in IDLE, ISSUE and RESP. A late pulse after a timeout is therefore dropped.
- Zero operands are forwarded unchanged; the core flags them.
- The result registers are reloaded only on the WAIT→RESP transition.

## Timing
- Reset values:
  - State IDLE, so `REQ_READY`=1.
  - `GCD_START`, `RSP_VALID`, `RSP_ERR`, `RSP_TIMEOUT` = 0.
  - `RSP_Y`, `GCD_A`, `GCD_B` = 0.
  - Timer = 0.
- Handshake cycle numbering, with acceptance in cycle k:
  - `GCD_START` is high in cycle k+1.
  - WAIT begins in cycle k+2.
  - A core pulse in cycle m gives `RSP_VALID`=1 in cycle m+1.
- Timeout: with no pulse, `RSP_VALID` rises in cycle k+2+`TIMEOUT_CYCLES`.
- Minimum acceptance-to-acceptance interval: 4 cycles (core pulse in the first WAIT cycle, `RSP_READY` tied high).
- `REQ_READY` is a function of state only; it has no combinational path from `REQ_VALID`.
- `RSP_VALID` is held until `RSP_READY`; there is no combinational `RSP_READY`→`REQ_READY` path.
- Asserting `RST_N` low in any state returns immediately to reset values; any in-flight result is discarded.

## Structure
- Shared package `gcd_pkg` holds:
  - the state enum `gcd_req_state_t` (IDLE/ISSUE/WAIT/RESP);
  - `GCD_WIDTH`=8;
  - `GCD_TIMEOUT_DEFAULT`=512.
- One sub-module, `gcd_timeout_cnt`:
  - `$clog2(TIMEOUT_CYCLES)`-bit counter with clear and enable inputs;
  - `expired` output, high when count = `TIMEOUT_CYCLES`-1;
  - saturating, no wrap-around.
- The FSM, operand registers and result registers live in the top module.

## Test plan
The bench pairs the block with the real `GCD` core, plus a behavioural core model with configurable latency for the timeout and pulse-collision cases.

1. Basic result:
   - Stimulus: request A=48, B=18 on the real core, `RSP_READY`=1.
   - Required: one `GCD_START` pulse; then `RSP_Y`=6, `RSP_ERR`=0, `RSP_TIMEOUT`=0; `REQ_READY` high again the cycle after the response is taken.
2. Zero operand:
   - Stimulus: A=0, B=25.
   - Required: `RSP_ERR`=1, `RSP_Y`=0.
3. Response backpressure:
   - Stimulus: A=255, B=85 with `RSP_READY`=0 for 10 cycles.
   - Required: `RSP_VALID` held with `RSP_Y`=85 stable; `REQ_READY`=0 throughout; a new `REQ_VALID` is not accepted.
4. Timeout, then late pulse dropped:
   - Stimulus: model never responds, `TIMEOUT_CYCLES`=8.
   - Required: `RSP_VALID` in cycle k+10 with `RSP_TIMEOUT`=1; a `GCD_DONE` injected afterwards does not change `RSP_Y`.
5. Simultaneous pulses and timeout collision:
   - Stimulus: `GCD_DONE` and `GCD_ERROR` high together.
   - Required: `RSP_ERR`=1.
   - Stimulus: a pulse arrives on the expiry cycle.
   - Required: `RSP_TIMEOUT`=0.
6. Reset mid-operation:
   - Stimulus: drop `RST_N` during WAIT.
   - Required: all outputs go to reset values immediately; `REQ_READY`=1 after release; the next request A=7, B=21 returns 7.
